// File: rtl/loadable_program_memory.sv
// Loadable instruction store: byte-wide big-endian program load, registered fetch port.
// Optional IMEM_PARITY_EN adds an even-parity bit per stored word and a parity_err output.
module loadable_program_memory #(
   parameter int unsigned AddrSz        = 6,
   parameter int unsigned InstructionSz = 24
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_start,
   input  logic                     load_valid,
   input  logic [7:0]               load_data,
   input  logic                     load_last,
   output logic                     load_ready,
   output logic                     load_done,
   output logic                     cpu_hold,
   input  logic                     fetch_en,
   input  logic [AddrSz-1:0]        address,
   output logic [InstructionSz-1:0] instruction,
   output logic                     instr_valid,
   output logic                     parity_err
);

   localparam int unsigned Depth        = 1 << AddrSz;
   localparam int unsigned BytesPerWord = (InstructionSz + 7) / 8;
   localparam int unsigned AsmW         = 8 * BytesPerWord;
   localparam int unsigned CntW         = (BytesPerWord > 1) ? $clog2(BytesPerWord) : 1;
`ifdef IMEM_PARITY_EN
   localparam int unsigned MemW = InstructionSz + 1;
`else
   localparam int unsigned MemW = InstructionSz;
`endif

   typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

   state_e                   state_q, state_d;
   logic [AddrSz-1:0]        ptr_q, ptr_d;
   logic [CntW-1:0]          bytecnt_q, bytecnt_d;
   logic [AsmW-1:0]          asm_q, asm_d;
   logic                     load_done_q, load_done_d;
   logic [InstructionSz-1:0] instr_q, instr_d;
   logic                     valid_q, valid_d;
   logic                     perr_q, perr_d;

   logic [MemW-1:0]          mem [Depth];
   logic [MemW-1:0]          rd_word;
   logic [MemW-1:0]          mem_wdata;
   logic                     mem_we;
   logic [AsmW-1:0]          asm_next;
   logic [InstructionSz-1:0] wr_word;
   logic                     accept;
   logic                     word_end;

   assign accept   = (state_q == StLoad) && load_valid && !load_start;
   assign word_end = load_last || (bytecnt_q == CntW'(BytesPerWord - 1));
   assign rd_word  = mem[address];

   // Each byte lands in its final big-endian slot; unreceived low bytes stay zero.
   always_comb begin
      asm_next = (bytecnt_q == '0) ? '0 : asm_q;
      for (int unsigned k = 0; k < BytesPerWord; k++) begin
         if (CntW'(k) == bytecnt_q) begin
            asm_next[8*(BytesPerWord-1-k) +: 8] = load_data;
         end
      end
   end

   // Keeping only the low bits also drops the unused high bits of the first byte.
   assign wr_word = asm_next[InstructionSz-1:0];
`ifdef IMEM_PARITY_EN
   assign mem_wdata = {^wr_word, wr_word};
`else
   assign mem_wdata = wr_word;
`endif

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      bytecnt_d   = bytecnt_q;
      asm_d       = asm_q;
      load_done_d = 1'b0;
      instr_d     = instr_q;
      valid_d     = 1'b0;
      perr_d      = 1'b0;
      mem_we      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (load_start) begin
               state_d   = StLoad;
               ptr_d     = '0;
               bytecnt_d = '0;
            end
         end
         StLoad: begin
            if (load_start) begin
               ptr_d     = '0;
               bytecnt_d = '0;
            end else if (accept) begin
               asm_d     = asm_next;
               bytecnt_d = bytecnt_q + 1'b1;
               if (word_end) begin
                  mem_we    = 1'b1;
                  ptr_d     = ptr_q + 1'b1;
                  bytecnt_d = '0;
                  if (load_last || (&ptr_q)) begin
                     state_d     = StRun;
                     load_done_d = 1'b1;
                  end
               end
            end
         end
         StRun: begin
            if (load_start) begin
               state_d   = StLoad;
               ptr_d     = '0;
               bytecnt_d = '0;
            end else if (fetch_en) begin
               instr_d = rd_word[InstructionSz-1:0];
               valid_d = 1'b1;
`ifdef IMEM_PARITY_EN
               perr_d  = rd_word[InstructionSz] ^ (^rd_word[InstructionSz-1:0]);
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         ptr_q       <= '0;
         bytecnt_q   <= '0;
         asm_q       <= '0;
         load_done_q <= 1'b0;
         instr_q     <= '0;
         valid_q     <= 1'b0;
         perr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         bytecnt_q   <= bytecnt_d;
         asm_q       <= asm_d;
         load_done_q <= load_done_d;
         instr_q     <= instr_d;
         valid_q     <= valid_d;
         perr_q      <= perr_d;
      end
   end

   // Array is deliberately not reset so a reset mid-load keeps finished words.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[ptr_q] <= mem_wdata;
      end
   end

   assign load_ready  = (state_q == StLoad);
   assign load_done   = load_done_q;
   assign cpu_hold    = (state_q != StRun);
   assign instruction = instr_q;
   assign instr_valid = valid_q;
   assign parity_err  = perr_q;

endmodule
